id_ex_pipeline_reg: RTL and testbench

- Decode-to-execute pipeline register. Consumes the register file's combinational read data (RD1/RD2) plus decoded fields, and presents them to the execute stage one cycle later.
- Bypasses a same-cycle writeback into the captured operands, so the register file's write-at-edge / read-combinational gap never returns stale data.
- Detects load-use hazards, requests an upstream stall and inserts a bubble.
- Honours external stall and flush from branch resolution.

---
 rtl/id_ex_pipeline_reg.sv | 131 +++++++++++++
 tb/tb_id_ex_pipeline_reg.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register with writeback bypass, load-use bubble,
// stall hold-refresh and branch flush.
module id_ex_pipeline_reg #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [4:0]        in_rd,
  input  logic [XLEN-1:0]   in_rd1,
  input  logic [XLEN-1:0]   in_rd2,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              in_mem_read,
  input  logic              wb_we,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_wd,
  input  logic              stall,
  input  logic              flush,
  output logic              hazard_stall,
  output logic              out_valid,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_rd1,
  output logic [XLEN-1:0]   out_rd2,
  output logic [XLEN-1:0]   out_imm,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [4:0]        out_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              out_mem_read
);

  logic              r_valid;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_rd1;
  logic [XLEN-1:0]   r_rd2;
  logic [XLEN-1:0]   r_imm;
  logic [4:0]        r_rs1;
  logic [4:0]        r_rs2;
  logic [4:0]        r_rd;
  logic [CTRL_W-1:0] r_ctrl;
  logic              r_mem_read;

  logic              w_wb_live;
  logic              w_byp1_hit;
  logic              w_byp2_hit;
  logic              w_ref1_hit;
  logic              w_ref2_hit;
  logic              w_rd_match;
  logic              w_hazard;
  logic [XLEN-1:0]   w_byp1;
  logic [XLEN-1:0]   w_byp2;

  // x0 writes never count as a live writeback
  assign w_wb_live  = wb_we & (wb_rd != 5'd0);

  assign w_byp1_hit = w_wb_live & (wb_rd == in_rs1);
  assign w_byp2_hit = w_wb_live & (wb_rd == in_rs2);
  assign w_byp1     = w_byp1_hit ? wb_wd : in_rd1;
  assign w_byp2     = w_byp2_hit ? wb_wd : in_rd2;

  assign w_ref1_hit = r_valid & w_wb_live
                    & (wb_rd == r_rs1);
  assign w_ref2_hit = r_valid & w_wb_live
                    & (wb_rd == r_rs2);

  assign w_rd_match = (r_rd == in_rs1)
                    | (r_rd == in_rs2);
  assign w_hazard   = in_valid & r_valid
                    & r_mem_read
                    & (r_rd != 5'd0)
                    & w_rd_match;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_ctrl     <= '0;
      r_mem_read <= 1'b0;
    end else if (flush || (!stall && w_hazard)) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_ctrl     <= '0;
      r_mem_read <= 1'b0;
    end else if (stall) begin
      // held operands must still see writebacks retiring meanwhile
      if (w_ref1_hit) r_rd1 <= wb_wd;
      if (w_ref2_hit) r_rd2 <= wb_wd;
    end else begin
      r_valid    <= in_valid;
      r_pc       <= in_pc;
      r_rd1      <= w_byp1;
      r_rd2      <= w_byp2;
      r_imm      <= in_imm;
      r_rs1      <= in_rs1;
      r_rs2      <= in_rs2;
      r_rd       <= in_rd;
      r_ctrl     <= in_valid ? in_ctrl : '0;
      r_mem_read <= in_valid & in_mem_read;
    end
  end

  assign hazard_stall = w_hazard;
  assign out_valid    = r_valid;
  assign out_pc       = r_pc;
  assign out_rd1      = r_rd1;
  assign out_rd2      = r_rd2;
  assign out_imm      = r_imm;
  assign out_rs1      = r_rs1;
  assign out_rs2      = r_rs2;
  assign out_rd       = r_rd;
  assign out_ctrl     = r_ctrl;
  assign out_mem_read = r_mem_read;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Scoreboard bench for id_ex_pipeline_reg: directed scenarios
// plus randomized traffic against a slot-level reference model.
module tb_id_ex_pipeline_reg;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 12;

  typedef struct packed {
    logic              v;
    logic [XLEN-1:0]   pc;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm;
    logic [CTRL_W-1:0] ctrl;
    logic              mr;
    logic              wbwe;
    logic [4:0]        wbrd;
    logic [XLEN-1:0]   wbwd;
    logic              st;
    logic              fl;
  } in_t;

  typedef struct packed {
    logic              care;
    logic              v;
    logic [XLEN-1:0]   pc;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm;
    logic [CTRL_W-1:0] ctrl;
    logic              mr;
  } ex_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic [XLEN-1:0]   in_pc = '0;
  logic [4:0]        in_rs1 = '0;
  logic [4:0]        in_rs2 = '0;
  logic [4:0]        in_rd = '0;
  logic [XLEN-1:0]   in_rd1 = '0;
  logic [XLEN-1:0]   in_rd2 = '0;
  logic [XLEN-1:0]   in_imm = '0;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic              in_mem_read = 1'b0;
  logic              wb_we = 1'b0;
  logic [4:0]        wb_rd = '0;
  logic [XLEN-1:0]   wb_wd = '0;
  logic              stall = 1'b0;
  logic              flush = 1'b0;
  logic              hazard_stall;
  logic              out_valid;
  logic [XLEN-1:0]   out_pc;
  logic [XLEN-1:0]   out_rd1;
  logic [XLEN-1:0]   out_rd2;
  logic [XLEN-1:0]   out_imm;
  logic [4:0]        out_rs1;
  logic [4:0]        out_rs2;
  logic [4:0]        out_rd;
  logic [CTRL_W-1:0] out_ctrl;
  logic              out_mem_read;

  id_ex_pipeline_reg #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_pc(in_pc),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_rd1(in_rd1), .in_rd2(in_rd2), .in_imm(in_imm),
    .in_ctrl(in_ctrl), .in_mem_read(in_mem_read),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_wd(wb_wd),
    .stall(stall), .flush(flush),
    .hazard_stall(hazard_stall),
    .out_valid(out_valid), .out_pc(out_pc),
    .out_rd1(out_rd1), .out_rd2(out_rd2), .out_imm(out_imm),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_ctrl(out_ctrl), .out_mem_read(out_mem_read)
  );

  always #5 clk = ~clk;

  int  errors = 0;
  int  checks = 0;
  ex_t model = '0;
  ex_t expq[$];

  task automatic chk(string nm, logic [XLEN-1:0] act,
                     logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic model_hz(ex_t m, in_t i);
    return i.v && m.v && m.mr && m.rd != 0 &&
           (m.rd == i.rs1 || m.rd == i.rs2);
  endfunction

  // slot semantics: what EX should hold after one edge
  function automatic ex_t model_next(ex_t m, in_t i);
    ex_t n = m;
    logic live = i.wbwe && i.wbrd != 0;
    if (i.fl || (!i.st && model_hz(m, i))) begin
      n = '0;
    end else if (i.st) begin
      if (m.v && live && i.wbrd == m.rs1) n.rd1 = i.wbwd;
      if (m.v && live && i.wbrd == m.rs2) n.rd2 = i.wbwd;
    end else begin
      n.care = 1'b1;
      n.v    = i.v;
      n.pc   = i.pc;
      n.rs1  = i.rs1;
      n.rs2  = i.rs2;
      n.rd   = i.rd;
      n.imm  = i.imm;
      n.rd1  = (live && i.wbrd == i.rs1) ? i.wbwd : i.rd1;
      n.rd2  = (live && i.wbrd == i.rs2) ? i.wbwd : i.rd2;
      n.ctrl = i.v ? i.ctrl : '0;
      n.mr   = i.v && i.mr;
    end
    return n;
  endfunction

  function automatic in_t idle();
    in_t i = '0;
    return i;
  endfunction

  function automatic in_t rand_in();
    in_t i;
    i.v    = ($urandom_range(0, 9) != 0);
    i.pc   = $urandom;
    i.rs1  = 5'($urandom_range(0, 6));
    i.rs2  = 5'($urandom_range(0, 6));
    i.rd   = 5'($urandom_range(0, 6));
    i.rd1  = $urandom;
    i.rd2  = $urandom;
    i.imm  = $urandom;
    i.ctrl = CTRL_W'($urandom);
    i.mr   = ($urandom_range(0, 2) == 0);
    i.wbwe = $urandom_range(0, 1) == 1;
    i.wbrd = 5'($urandom_range(0, 6));
    i.wbwd = $urandom;
    i.st   = ($urandom_range(0, 7) == 0);
    i.fl   = ($urandom_range(0, 11) == 0);
    return i;
  endfunction

  task automatic apply(in_t i);
    in_valid    = i.v;
    in_pc       = i.pc;
    in_rs1      = i.rs1;
    in_rs2      = i.rs2;
    in_rd       = i.rd;
    in_rd1      = i.rd1;
    in_rd2      = i.rd2;
    in_imm      = i.imm;
    in_ctrl     = i.ctrl;
    in_mem_read = i.mr;
    wb_we       = i.wbwe;
    wb_rd       = i.wbrd;
    wb_wd       = i.wbwd;
    stall       = i.st;
    flush       = i.fl;
  endtask

  // drive one cycle; hazard is checked live, the slot via the queue
  task automatic drive(in_t i);
    @(negedge clk);
    apply(i);
    #1;
    chk("hazard_stall", XLEN'(hazard_stall),
        XLEN'(model_hz(model, i)));
    model = model_next(model, i);
    expq.push_back(model);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, " out_valid"}, XLEN'(out_valid), 0);
    chk({tag, " out_pc"}, out_pc, 0);
    chk({tag, " out_rd1"}, out_rd1, 0);
    chk({tag, " out_rd"}, XLEN'(out_rd), 0);
    chk({tag, " out_ctrl"}, XLEN'(out_ctrl), 0);
    chk({tag, " out_mem_read"}, XLEN'(out_mem_read), 0);
    chk({tag, " hazard_stall"}, XLEN'(hazard_stall), 0);
  endtask

  initial begin : monitor
    ex_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("sb out_valid", XLEN'(out_valid), XLEN'(e.v));
        chk("sb out_ctrl", XLEN'(out_ctrl), XLEN'(e.ctrl));
        chk("sb out_mem_read", XLEN'(out_mem_read), XLEN'(e.mr));
        chk("sb out_rd", XLEN'(out_rd), XLEN'(e.rd));
        if (e.care) begin
          chk("sb out_pc", out_pc, e.pc);
          chk("sb out_rs1", XLEN'(out_rs1), XLEN'(e.rs1));
          chk("sb out_rs2", XLEN'(out_rs2), XLEN'(e.rs2));
          chk("sb out_rd1", out_rd1, e.rd1);
          chk("sb out_rd2", out_rd2, e.rd2);
          chk("sb out_imm", out_imm, e.imm);
        end
      end
    end
  end

  initial begin : stim
    in_t i;
    int  n;

    apply(idle());
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    i = idle();
    i.v = 1; i.pc = 32'h100; i.rs1 = 5; i.rd1 = 32'h11; i.imm = 32'h4;
    drive(i);
    after_edge();
    chk("first out_valid", XLEN'(out_valid), 1);
    chk("first out_pc", out_pc, 32'h100);
    chk("first out_rd1", out_rd1, 32'h11);
    chk("first out_imm", out_imm, 32'h4);

    i = idle();
    i.v = 1; i.rs1 = 7; i.rd1 = 32'hAAAA;
    i.wbwe = 1; i.wbrd = 7; i.wbwd = 32'h1234;
    drive(i);
    after_edge();
    chk("bypass out_rd1", out_rd1, 32'h1234);

    i.rs1 = 0; i.rd1 = 0; i.wbrd = 0;
    drive(i);
    after_edge();
    chk("x0 no bypass out_rd1", out_rd1, 0);

    i = idle();
    i.v = 1; i.rd = 3; i.mr = 1; i.ctrl = 12'h5A5; i.pc = 32'h300;
    drive(i);
    i = idle();
    i.v = 1; i.rs2 = 3; i.rd = 4; i.ctrl = 12'h0F0; i.pc = 32'h304;
    drive(i);
    chk("loaduse hazard live", XLEN'(hazard_stall), 1);
    after_edge();
    chk("bubble out_valid", XLEN'(out_valid), 0);
    chk("bubble out_ctrl", XLEN'(out_ctrl), 0);
    drive(i);
    chk("post-bubble hazard", XLEN'(hazard_stall), 0);
    after_edge();
    chk("recapture out_valid", XLEN'(out_valid), 1);
    chk("recapture out_rs2", XLEN'(out_rs2), 3);

    i = idle();
    i.v = 1; i.rs1 = 9; i.pc = 32'h200; i.rd1 = 32'h77;
    drive(i);
    i = idle();
    i.st = 1; i.wbwe = 1; i.wbrd = 9; i.wbwd = 32'hBEEF;
    for (int k = 0; k < 3; k++) begin
      drive(i);
      after_edge();
      chk("hold out_rd1", out_rd1, 32'hBEEF);
      chk("hold out_pc", out_pc, 32'h200);
      chk("hold out_valid", XLEN'(out_valid), 1);
    end

    i = idle();
    i.v = 1; i.rd = 3; i.mr = 1; i.ctrl = 12'h111;
    drive(i);
    i = idle();
    i.v = 1; i.rs1 = 3; i.fl = 1; i.st = 1;
    drive(i);
    after_edge();
    chk("flush out_valid", XLEN'(out_valid), 0);
    chk("flush out_mem_read", XLEN'(out_mem_read), 0);
    chk("flush out_rd", XLEN'(out_rd), 0);

    for (int k = 0; k < 500; k++) begin
      drive(rand_in());
      if (k == 250) begin
        i = idle();
        i.v = 1; i.pc = 32'h400; i.rd = 2; i.ctrl = 12'hABC;
        drive(i);
        @(negedge clk);
        #2;
        chk("pre-async out_valid", XLEN'(out_valid), 1);
        rst = 1'b0;
        #1;
        chk_all_zero("async");
        expq.delete();
        model = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
      end
    end

    n = 0;
    while (expq.size() > 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    #3;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
